// File: rtl/result_window_acc.sv
// Collects a window of 1..2^WIN_W samples and reports their sum and maximum; out_valid rises the edge after the last accept.
// Backpressure: while a result waits in DONE, in_ready is low and out_valid holds until out_ready.
module result_window_acc #(
    parameter int WIN_W = 3
) (
    input  logic                  clk_n,
    input  logic                  reset_n,
    input  logic [14:0]           count_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIN_W-1:0]      win_len,
    output logic [15+WIN_W-1:0]   sum_out,
    output logic [14:0]           max_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int SUM_W = 15 + WIN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SUM_W-1:0]     sum_q,   sum_d;
    logic [14:0]          max_q,   max_d;
    logic [WIN_W:0]       cnt_q,   cnt_d;
    logic [WIN_W-1:0]     len_q,   len_d;
    logic                 ovld_q,  ovld_d;
    logic                 rdy_q,   rdy_d;
    logic                 accept;

    // rdy_q resets low and is only raised by a clock edge, so the reset-release edge can never accept.
    assign accept = in_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovld_d  = ovld_q;
        rdy_d   = rdy_q;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (accept) begin
                    len_d = win_len;
                    sum_d = SUM_W'(count_in);
                    max_d = count_in;
                    cnt_d = (WIN_W+1)'(1);
                    if (win_len == '0) begin
                        state_d = DONE;
                        ovld_d  = 1'b1;
                        rdy_d   = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                rdy_d = 1'b1;
                if (accept) begin
                    sum_d = sum_q + SUM_W'(count_in);
                    if (count_in > max_q) begin
                        max_d = count_in;
                    end
                    cnt_d = cnt_q + 1'b1;
                    // The incoming sample is number cnt_q+1; it closes the window when that equals len_q+1.
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = DONE;
                        ovld_d  = 1'b1;
                        rdy_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                rdy_d = 1'b0;
                if (out_ready) begin
                    state_d = IDLE;
                    ovld_d  = 1'b0;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ovld_d  = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_n or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            sum_q   <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovld_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovld_q  <= ovld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = ovld_q;
    assign sum_out   = sum_q;
    assign max_out   = max_q;

endmodule

// File: tb/tb_result_window_acc.sv
// Scoreboard bench for result_window_acc: expected sum/max pushed when a window's last sample is driven.
module tb_result_window_acc;

    logic        clk_n;
    logic        reset_n;
    logic [14:0] count_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  win_len;
    logic [17:0] sum_out;
    logic [14:0] max_out;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];

    result_window_acc #(.WIN_W(3)) dut (
        .clk_n     (clk_n),
        .reset_n   (reset_n),
        .count_in  (count_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_len   (win_len),
        .sum_out   (sum_out),
        .max_out   (max_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk_n = 1'b0;
    always #5 clk_n = ~clk_n;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer side: every handshaken result is popped and compared.
    always @(negedge clk_n) begin
        if (!reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("sum_out", sum_out, e[32:15]);
                chk("max_out", max_out, e[14:0]);
                chk("in_ready_done", in_ready, 0);
            end
        end
    end

    // Drive one sample and hold it until the edge that accepts it.
    task automatic send_sample(input logic [14:0] v);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        count_in = v;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_n);
            if (in_ready) ok = 1;
            @(posedge clk_n);
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", ok, 1);
    endtask

    task automatic idle_cycles(input int n, input bit chk_no_valid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_n);
            if (chk_no_valid) chk("early_valid", out_valid, 0);
            @(posedge clk_n);
            #1;
        end
    endtask

    task automatic send_window(input int len, input logic [14:0] s[8], input int gap);
        logic [17:0] es;
        logic [14:0] em;
        es = '0;
        em = '0;
        win_len = 3'(len);
        for (int i = 0; i <= len; i++) begin
            es = es + 18'(s[i]);
            if (s[i] > em) em = s[i];
        end
        for (int i = 0; i <= len; i++) begin
            if (i == len) exp_q.push_back({es, em});
            send_sample(s[i]);
            if (i != len && gap > 0) idle_cycles(gap, 1'b1);
        end
    endtask

    initial begin
        logic [14:0] s[8];

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        count_in  = '0;
        win_len   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_sum", sum_out, 0);
        chk("rst_max", max_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        #23;
        reset_n = 1'b0;
        @(posedge clk_n);
        #1;
        chk("ready_after_release", in_ready, 1);

        // Single-sample window
        s = '{2034, 0, 0, 0, 0, 0, 0, 0};
        send_window(0, s, 0);
        chk("single_valid_next_edge", out_valid, 1);
        chk("single_in_ready", in_ready, 0);
        idle_cycles(2, 1'b0);

        // Four samples with gaps
        s = '{100, 500, 300, 200, 0, 0, 0, 0};
        send_window(3, s, 1);
        idle_cycles(2, 1'b0);

        // Full-scale window back-to-back
        s = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        send_window(7, s, 0);
        idle_cycles(2, 1'b0);

        // Ties keep the max
        s = '{5, 5, 3, 0, 0, 0, 0, 0};
        send_window(2, s, 0);
        idle_cycles(2, 1'b0);

        // Backpressure in DONE
        out_ready = 1'b0;
        s = '{50, 0, 0, 0, 0, 0, 0, 0};
        send_window(0, s, 0);
        in_valid = 1'b1;
        count_in = 15'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_n);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", sum_out, 50);
            chk("bp_max", max_out, 50);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk_n);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_cycles(2, 1'b0);
        s = '{10, 20, 0, 0, 0, 0, 0, 0};
        send_window(1, s, 0);
        idle_cycles(2, 1'b0);

        // Reset mid-window
        win_len = 3'd3;
        send_sample(15'd400);
        send_sample(15'd600);
        #2;
        reset_n = 1'b1;
        #1;
        chk("midrst_sum", sum_out, 0);
        chk("midrst_max", max_out, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk_n);
        win_len  = 3'd0;
        in_valid = 1'b1;
        count_in = 15'd7;
        reset_n  = 1'b0;
        #1;
        chk("release_in_ready", in_ready, 0);
        s = '{7, 0, 0, 0, 0, 0, 0, 0};
        send_window(0, s, 0);
        idle_cycles(3, 1'b0);

        // win_len changed after the first accept
        win_len = 3'd1;
        send_sample(15'd1000);
        win_len = 3'd5;
        exp_q.push_back({18'd3000, 15'd2000});
        send_sample(15'd2000);
        chk("wl_change_valid", out_valid, 1);
        idle_cycles(3, 1'b0);

        // Random windows
        for (int w = 0; w < 6; w++) begin
            int len;
            len = int'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) s[i] = 15'($urandom);
            send_window(len, s, int'($urandom_range(0, 2)));
            idle_cycles(2, 1'b0);
        end

        idle_cycles(3, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
